// File: rtl/zube_pkg.sv
// Shared constants for the zube mailbox: status byte layout, reset value, level helper.
package zube_pkg;
  localparam int ST_RXA     = 0;
  localparam int ST_TXS     = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_UNF     = 3;
  localparam int ST_LVL_LSB = 4;

  localparam logic [7:0] ST_RESET = 8'h02;

  // Occupancy squeezed into the 4-bit status nibble.
  function automatic logic [3:0] sat_lvl(input int c);
    return (c >= 15) ? 4'hF : 4'(c);
  endfunction
endpackage

// File: rtl/zube_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a registered count. Exposes the
// next-cycle head and count so the owner can register its outputs directly.
module zube_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] nxt_head_o,
  output logic [CW-1:0]    nxt_count_o
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d  = wr_q + (AW+1)'(do_push);
    rd_d  = rd_q + (AW+1)'(do_pop);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    // Bypass the write when it lands on the slot that becomes the head.
    if (do_push && (wr_q[AW-1:0] == rd_d[AW-1:0])) nxt_head_o = wdata_i;
    else                                           nxt_head_o = mem[rd_d[AW-1:0]];
  end

  assign nxt_count_o = cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/zube_mailbox_fifo.sv
// zube mailbox buffering: RX (Z80->SoC) and TX (SoC->Z80) FIFOs, sticky flags, status byte.
// Define ZUBE_MAILBOX_LEVEL_EN to report TX occupancy in z80_status[7:4].
module zube_mailbox_fifo
  import zube_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             z80_wr_valid,
  input  logic [WIDTH-1:0] z80_wr_data,
  input  logic             z80_rd_ack,
  input  logic             z80_flag_clr,
  output logic [WIDTH-1:0] z80_rd_data,
  output logic [7:0]       z80_status,
  output logic             soc_rx_valid,
  output logic [WIDTH-1:0] soc_rx_data,
  input  logic             soc_rx_ready,
  input  logic             soc_tx_valid,
  input  logic [WIDTH-1:0] soc_tx_data,
  output logic             soc_tx_ready
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             rx_full, rx_empty, tx_full, tx_empty;
  logic [WIDTH-1:0] rx_head_nxt, tx_head_nxt;
  logic [CW-1:0]    rx_cnt_nxt, tx_cnt_nxt;
  logic             rx_pop, tx_push, tx_pop, ovf_set, unf_set;

  logic             rx_valid_q, rx_valid_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d, tx_data_q, tx_data_d;
  logic [7:0]       status_q, status_d;

  assign rx_pop       = !rx_empty && soc_rx_ready;
  assign tx_pop       = z80_rd_ack && !tx_empty;
  assign soc_tx_ready = !tx_full || tx_pop;
  assign tx_push      = soc_tx_valid && soc_tx_ready;
  assign ovf_set      = z80_wr_valid && rx_full && !rx_pop;
  assign unf_set      = z80_rd_ack && tx_empty;

  zube_sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_rx (
    .clk(clk), .reset(reset),
    .push_i(z80_wr_valid), .pop_i(rx_pop), .wdata_i(z80_wr_data),
    .full_o(rx_full), .empty_o(rx_empty),
    .nxt_head_o(rx_head_nxt), .nxt_count_o(rx_cnt_nxt)
  );

  zube_sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_tx (
    .clk(clk), .reset(reset),
    .push_i(tx_push), .pop_i(z80_rd_ack), .wdata_i(soc_tx_data),
    .full_o(tx_full), .empty_o(tx_empty),
    .nxt_head_o(tx_head_nxt), .nxt_count_o(tx_cnt_nxt)
  );

  always_comb begin
    rx_valid_d = (rx_cnt_nxt != '0);
    rx_data_d  = rx_valid_d ? rx_head_nxt : '0;
    tx_data_d  = (tx_cnt_nxt != '0) ? tx_head_nxt : '0;

    status_d             = '0;
    status_d[ST_RXA]     = (tx_cnt_nxt != '0);
    status_d[ST_TXS]     = (rx_cnt_nxt != CW'(DEPTH));
    // Set beats a coincident clear.
    status_d[ST_OVF]     = ovf_set || (status_q[ST_OVF] && !z80_flag_clr);
    status_d[ST_UNF]     = unf_set || (status_q[ST_UNF] && !z80_flag_clr);
`ifdef ZUBE_MAILBOX_LEVEL_EN
    status_d[ST_LVL_LSB +: 4] = sat_lvl(int'(tx_cnt_nxt));
`else
    status_d[ST_LVL_LSB +: 4] = 4'h0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      tx_data_q  <= '0;
      status_q   <= ST_RESET;
    end else begin
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      tx_data_q  <= tx_data_d;
      status_q   <= status_d;
    end
  end

  assign soc_rx_valid = rx_valid_q;
  assign soc_rx_data  = rx_data_q;
  assign z80_rd_data  = tx_data_q;
  assign z80_status   = status_q;
endmodule

// File: doc/zube_mailbox_fifo.md
# zube_mailbox_fifo

SoC-side buffering stage for the zube Z80 mailbox. It takes byte writes and read-completions from the Z80 bus interface and queues Z80→SoC bytes in a DEPTH-entry FIFO, presented to the SoC as a valid/ready stream. In the other direction it queues SoC→Z80 bytes in a second FIFO, whose head drives the mailbox Data In register. It also builds the Status In byte that the Z80 polls.

## Interface
Parameters:
- DEPTH, 4, entries per FIFO; power of two, 2..16.
- WIDTH, 8, data width; fixed at 8 for the Z80 bus.

Ports:
- Clock and reset: one clock `clk`; reset `reset` is asynchronous and active-high.
- clk  in  1  system clock (same domain as the mailbox).
- reset  in  1  asynchronous, active-high reset.
- z80_wr_valid  in  1  one-cycle pulse: the Z80 wrote the Data Out port.
- z80_wr_data  in  8  byte written by the Z80; sampled when z80_wr_valid=1.
- z80_rd_ack  in  1  one-cycle pulse: the Z80 finished reading Data In. Pops the SoC→Z80 FIFO.
- z80_flag_clr  in  1  one-cycle pulse: clears both sticky error flags.
- z80_rd_data  out  8  head of the SoC→Z80 FIFO; 8'h00 when empty.
- z80_status  out  8  status byte (see Operation).
- soc_rx_valid  out  1  Z80→SoC FIFO is non-empty.
- soc_rx_data  out  8  head of the Z80→SoC FIFO; 8'h00 when empty.
- soc_rx_ready  in  1  SoC consumes the head when soc_rx_valid & soc_rx_ready.
- soc_tx_valid  in  1  SoC offers a byte.
- soc_tx_data  in  8  byte offered by the SoC.
- soc_tx_ready  out  1  SoC→Z80 FIFO can accept a byte this cycle.

## Operation
- **Two independent FIFOs**: RX (Z80→SoC) and TX (SoC→Z80). Each has read and write pointers with one extra wrap bit, and a registered count.
- **RX push**: on z80_wr_valid. It is accepted if RX is not full, or if an RX pop happens in the same cycle.
  - A push to a full RX with no simultaneous pop drops the byte and sets the sticky OVF flag.
- **RX pop**: on soc_rx_valid & soc_rx_ready.
- **TX push**: on soc_tx_valid & soc_tx_ready.
  - soc_tx_ready = !tx_full | tx_pop, driven combinationally.
- **TX pop**: on z80_rd_ack when TX is non-empty.
  - z80_rd_ack on an empty TX changes no pointers and sets the sticky UNF flag.
  - If a push lands on an empty TX in the same cycle as z80_rd_ack, the push succeeds, the pop is ignored, and UNF is set.
- **Status byte**:
  - bit0 RXA: TX is non-empty (the Z80 has data to read).
  - bit1 TXS: RX is not full (the Z80 may write).
  - bit2 OVF.
  - bit3 UNF.
  - bits7:4 LVL (see Configuration).
- **Sticky flags**: z80_flag_clr clears OVF and UNF. If a set event and a clear occur in the same cycle, set wins.
- **Pointer wrap**: pointers wrap modulo DEPTH. full = (addresses equal) & (wrap bits differ).

## Timing
- **Reset values** (immediately on reset assert; asynchronous):
  - Both FIFOs empty, OVF=0, UNF=0.
  - soc_rx_valid=0, soc_rx_data=8'h00, z80_rd_data=8'h00.
  - z80_status=8'h02, soc_tx_ready=1.
- **Reset mid-operation**: discards all queued bytes. A pulse coincident with reset deassertion is ignored.
- **Latency**:
  - A byte accepted at edge N appears on soc_rx_data/soc_rx_valid (RX) or on z80_rd_data/z80_status (TX) after edge N. That is one cycle, with no fall-through.
  - A pop at edge N presents the next head after edge N.
- **Registered outputs**: all outputs except soc_tx_ready are registered. Head data comes from flops or a registered read, not a combinational mux of the pointer.
- **Sustained throughput**: one push and one pop per FIFO per cycle.

## Configuration
- ZUBE_MAILBOX_LEVEL_EN defined: z80_status[7:4] = TX occupancy, saturating at 15.
- ZUBE_MAILBOX_LEVEL_EN undefined: z80_status[7:4] = 4'h0 and the level-reporting logic is absent.
- All other behaviour is identical with or without the macro.

## Structure
- **Package zube_pkg**: status bit index constants (ST_RXA=0, ST_TXS=1, ST_OVF=2, ST_UNF=3, ST_LVL_LSB=4) and the reset status value 8'h02.
- **Sub-module zube_sync_fifo** (DEPTH, WIDTH): push, pop, full, empty, count, head. It is instantiated twice.
- **Top level** owns the sticky flags, the status byte and the empty-head zeroing.

## Test plan
1. **Loopback**: Z80 writes 8'hA5, 8'h3C → soc_rx_data shows A5 one cycle after the first pulse; after one handshake shows 3C; soc_rx_valid falls after the second handshake.
2. **RX overflow**: 5 writes with DEPTH=4 and soc_rx_ready=0 → 5th byte dropped, z80_status[2]=1, z80_status[1]=0; pulse z80_flag_clr → bit2=0.
3. **Full with pop**: RX full; z80_wr_valid and SoC pop in the same cycle → both succeed, no OVF, count stays 4.
4. **TX path**: SoC pushes 8'h11, 8'h22 → z80_rd_data=11, status bit0=1; z80_rd_ack → 22; with ZUBE_MAILBOX_LEVEL_EN, status[7:4] goes 2→1→0.
5. **Underflow**: z80_rd_ack on empty TX → UNF=1, z80_rd_data stays 00; a simultaneous z80_flag_clr still leaves UNF=1.
6. **Reset mid-traffic**: three bytes queued in each FIFO, assert reset → all outputs at reset values the same cycle; after release, the first new push is delivered correctly.
